// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, word geometry
// and the byte-lane merge used for masked writes.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dmem_state_e;

  // Replace the lanes selected by mask with the matching bytes of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word SRAM with byte-lane write mask and a registered, write-first read.
// Kept behind this boundary so a vendor macro can be dropped in.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_in,
  input  logic [DEPTH_LOG2-1:0] addr_in,
  input  logic [31:0]           wdata_in,
  input  logic [3:0]            wmask_in,
  input  logic                  we_in,
  output logic [31:0]           rdata_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // NOTE: the storage array has no reset; a reset term would stop it mapping onto
  // SRAM, so the responder's clear sequencer initialises it instead.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  assign w_merged  = byte_merge(r_mem[addr_in], wdata_in, wmask_in);
  assign rdata_out = r_rdata;

  always_ff @(posedge clk_in) begin
    if (we_in) begin
      r_mem[addr_in] <= w_merged;
      r_rdata        <= w_merged;
    end else begin
      r_rdata        <= r_mem[addr_in];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's dmem port: range check, clear-after-reset
// sequencer and registered reads. Define DMEM_PERF_CNT_EN to add read/write counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  output logic [31:0] dmdata_out,
  output logic        addr_err_out,
  output logic        busy_out
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt_out,
  output logic [31:0] wr_cnt_out
`endif
);

  localparam logic [32:0] ADDR_LIMIT = 33'(WORD_BYTES) << DEPTH_LOG2;

  dmem_state_e           r_state;
  logic [DEPTH_LOG2-1:0] r_clear_idx;
  logic                  r_rd_ok;
  logic                  r_addr_err;

  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic                  w_run;
  logic                  w_port_wr;
  logic [DEPTH_LOG2-1:0] w_arr_addr;
  logic [31:0]           w_arr_wdata;
  logic [3:0]            w_arr_mask;
  logic                  w_arr_we;
  logic [31:0]           w_arr_rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the same compare.
  assign w_offset   = dmaddr_in - BASE_ADDR;
  assign w_in_range = {1'b0, w_offset} < ADDR_LIMIT;
  assign w_run      = (r_state == RUN);
  assign w_port_wr  = w_run && dmwr_req_in && w_in_range && (dmwr_mask_in != 4'b0000);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_arr_addr  = r_clear_idx;
    w_arr_wdata = 32'h0;
    w_arr_mask  = 4'hF;
    w_arr_we    = 1'b1;
    if (w_run) begin
      w_arr_addr  = w_offset[DEPTH_LOG2+1:2];
      w_arr_wdata = dmdata_in;
      w_arr_mask  = dmwr_mask_in;
      w_arr_we    = w_port_wr;
    end
  end

  dmem_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_in    (clk_in),
    .addr_in   (w_arr_addr),
    .wdata_in  (w_arr_wdata),
    .wmask_in  (w_arr_mask),
    .we_in     (w_arr_we),
    .rdata_out (w_arr_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= CLEAR;
      r_clear_idx <= '0;
      r_rd_ok     <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clear_idx <= r_clear_idx + 1'b1;
          r_rd_ok     <= 1'b0;
          r_addr_err  <= 1'b0;
          if (r_clear_idx == '1) r_state <= RUN;
        end
        default: begin
          r_rd_ok    <= w_in_range;
          r_addr_err <= !w_in_range;
        end
      endcase
    end
  end

  // Array read data is gated so CLEAR cycles and bad addresses return zero.
  assign dmdata_out   = r_rd_ok ? w_arr_rdata : 32'h0;
  assign addr_err_out = r_addr_err;
  assign busy_out     = (r_state == CLEAR);

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_cnt <= 32'h0;
      r_wr_cnt <= 32'h0;
    end else if (w_run) begin
      if (w_port_wr)       r_wr_cnt <= r_wr_cnt + 32'd1;
      else if (w_in_range) r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign rd_cnt_out = r_rd_cnt;
  assign wr_cnt_out = r_wr_cnt;
`endif

endmodule
